// File: rtl/io_pkg.sv
// Shared sizes and the per-button debounce state encoding for the board input conditioner.
package io_pkg;

  localparam int NUM_BTN = 4;
  localparam int NUM_SW  = 32;

  typedef enum logic [1:0] {
    REL     = 2'd0,
    PEND_DN = 2'd1,
    PRS     = 2'd2,
    PEND_UP = 2'd3
  } db_state_e;

endpackage

// File: rtl/io_input_cond_if.sv
// Board-side raw inputs and conditioned outputs bundled between the pins and the CPU IO port.
interface io_input_cond_if;
  import io_pkg::*;

  logic [NUM_SW-1:0]  i_sw_raw;
  logic [NUM_BTN-1:0] i_btn_raw_n;
  logic [NUM_SW-1:0]  o_io_sw;
  logic [NUM_BTN-1:0] o_io_btn;
  logic [NUM_BTN-1:0] o_btn_press;
  logic [NUM_BTN-1:0] o_btn_release;

  modport master (
    output i_sw_raw,
    output i_btn_raw_n,
    input  o_io_sw,
    input  o_io_btn,
    input  o_btn_press,
    input  o_btn_release
  );

  modport slave (
    input  i_sw_raw,
    input  i_btn_raw_n,
    output o_io_sw,
    output o_io_btn,
    output o_btn_press,
    output o_btn_release
  );

endinterface

// File: rtl/debounce_ch.sv
// One push-button channel: invert, synchronize, debounce with a 4-state FSM, emit edge pulses.
module debounce_ch
  import io_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 50000,
  parameter int SYNC_STAGES     = 2
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_btn_raw_n,
  output logic o_btn,
  output logic o_press,
  output logic o_release
);

  localparam int             CW     = $clog2(DEBOUNCE_CYCLES + 1);
  // The edge that commits a level change is the one that would bring the count to DEBOUNCE_CYCLES.
  localparam logic [CW-1:0]  C_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic [SYNC_STAGES-1:0] r_sync;
  logic                   w_sync_btn;
  db_state_e              r_state;
  logic [CW-1:0]          r_cnt;
  logic                   r_btn;
  logic                   r_press;
  logic                   r_release;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_sync <= '0;
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], ~i_btn_raw_n};
    end
  end

  assign w_sync_btn = r_sync[SYNC_STAGES-1];

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state   <= REL;
      r_cnt     <= '0;
      r_btn     <= 1'b0;
      r_press   <= 1'b0;
      r_release <= 1'b0;
    end else begin
      r_press   <= 1'b0;
      r_release <= 1'b0;
      case (r_state)
        REL: begin
          if (w_sync_btn) begin
            r_state <= PEND_DN;
            r_cnt   <= CW'(1);
          end
        end
        PEND_DN: begin
          if (!w_sync_btn) begin
            r_state <= REL;
            r_cnt   <= '0;
          end else if (r_cnt >= C_LAST) begin
            r_state <= PRS;
            r_cnt   <= '0;
            r_btn   <= 1'b1;
            r_press <= 1'b1;
          end else begin
            r_cnt <= r_cnt + CW'(1);
          end
        end
        PRS: begin
          if (!w_sync_btn) begin
            r_state <= PEND_UP;
            r_cnt   <= CW'(1);
          end
        end
        PEND_UP: begin
          if (w_sync_btn) begin
            r_state <= PRS;
            r_cnt   <= '0;
          end else if (r_cnt >= C_LAST) begin
            r_state   <= REL;
            r_cnt     <= '0;
            r_btn     <= 1'b0;
            r_release <= 1'b1;
          end else begin
            r_cnt <= r_cnt + CW'(1);
          end
        end
        default: begin
          r_state <= REL;
          r_cnt   <= '0;
          r_btn   <= 1'b0;
        end
      endcase
    end
  end

  assign o_btn     = r_btn;
  assign o_press   = r_press;
  assign o_release = r_release;

endmodule

// File: rtl/io_input_cond.sv
// Board input conditioner: synchronizes switches and debounces active-low push-buttons for the CPU.
module io_input_cond
  import io_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 50000,
  parameter int SYNC_STAGES     = 2
) (
  input  logic            i_clk,
  input  logic            i_rst_n,
  io_input_cond_if.slave  io
);

  generate
    if (DEBOUNCE_CYCLES < 1 || SYNC_STAGES < 2) begin : g_bad_params
      $error("io_input_cond: DEBOUNCE_CYCLES must be >= 1 and SYNC_STAGES >= 2");
    end
  endgenerate

  logic [NUM_SW-1:0]  r_sw_sync [SYNC_STAGES];
  logic [NUM_BTN-1:0] w_btn;
  logic [NUM_BTN-1:0] w_press;
  logic [NUM_BTN-1:0] w_release;

  // Switches are level-only: synchronized but deliberately not debounced.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int unsigned k = 0; k < SYNC_STAGES; k++) begin
        r_sw_sync[k] <= '0;
      end
    end else begin
      r_sw_sync[0] <= io.i_sw_raw;
      for (int unsigned k = 1; k < SYNC_STAGES; k++) begin
        r_sw_sync[k] <= r_sw_sync[k-1];
      end
    end
  end

  for (genvar g = 0; g < NUM_BTN; g++) begin : g_ch
    debounce_ch #(
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
      .SYNC_STAGES     (SYNC_STAGES)
    ) u_ch (
      .i_clk       (i_clk),
      .i_rst_n     (i_rst_n),
      .i_btn_raw_n (io.i_btn_raw_n[g]),
      .o_btn       (w_btn[g]),
      .o_press     (w_press[g]),
      .o_release   (w_release[g])
    );
  end

  assign io.o_io_sw       = r_sw_sync[SYNC_STAGES-1];
  assign io.o_io_btn      = w_btn;
  assign io.o_btn_press   = w_press;
  assign io.o_btn_release = w_release;

endmodule

// File: tb/tb_io_input_cond.sv
// Directed bench for io_input_cond with DEBOUNCE_CYCLES=4, SYNC_STAGES=2.
module tb_io_input_cond;
  import io_pkg::*;

  localparam int DB = 4;
  localparam int SS = 2;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  io_input_cond_if bus ();

  io_input_cond #(
    .DEBOUNCE_CYCLES (DB),
    .SYNC_STAGES     (SS)
  ) dut (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .io      (bus.slave)
  );

  typedef struct {
    logic [31:0] sw;
    logic [3:0]  btn_n;
    logic [31:0] e_sw;
    logic [3:0]  e_btn;
    logic [3:0]  e_pr;
    logic [3:0]  e_rel;
  } vec_t;

  vec_t vecs[$];
  int   n_vec = 0;
  int   n_bad = 0;

  function automatic void add(int rep, logic [31:0] sw, logic [3:0] bn,
                              logic [31:0] esw, logic [3:0] eb, logic [3:0] ep, logic [3:0] er);
    vec_t v;
    v = '{sw, bn, esw, eb, ep, er};
    for (int i = 0; i < rep; i++) vecs.push_back(v);
  endfunction

  task automatic chk(string name, logic [31:0] esw, logic [3:0] eb, logic [3:0] ep, logic [3:0] er);
    n_vec++;
    if (bus.o_io_sw !== esw || bus.o_io_btn !== eb || bus.o_btn_press !== ep || bus.o_btn_release !== er) begin
      n_bad++;
      $display("FAIL %s: got sw=%h btn=%h press=%h rel=%h, expected sw=%h btn=%h press=%h rel=%h",
               name, bus.o_io_sw, bus.o_io_btn, bus.o_btn_press, bus.o_btn_release, esw, eb, ep, er);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    bus.i_sw_raw    = '0;
    bus.i_btn_raw_n = '1;

    // Rows: inputs applied before an edge, expected outputs just after it.
    add(1, 32'hA5A5_0F0F, 4'hF, 32'h0,         4'h0, 4'h0, 4'h0);
    add(1, 32'hA5A5_0F0F, 4'hF, 32'hA5A5_0F0F, 4'h0, 4'h0, 4'h0);
    add(1, 32'h0,         4'hF, 32'hA5A5_0F0F, 4'h0, 4'h0, 4'h0);
    add(1, 32'h0,         4'hF, 32'h0,         4'h0, 4'h0, 4'h0);
    add(5, 32'h0,         4'hE, 32'h0,         4'h0, 4'h0, 4'h0);
    add(1, 32'h0,         4'hE, 32'h0,         4'h1, 4'h1, 4'h0);
    add(1, 32'h0,         4'hE, 32'h0,         4'h1, 4'h0, 4'h0);
    add(3, 32'h0,         4'hC, 32'h0,         4'h1, 4'h0, 4'h0);
    add(3, 32'h0,         4'hE, 32'h0,         4'h1, 4'h0, 4'h0);
    add(5, 32'h0,         4'hF, 32'h0,         4'h1, 4'h0, 4'h0);
    add(1, 32'h0,         4'hF, 32'h0,         4'h0, 4'h0, 4'h1);
    add(1, 32'h0,         4'hF, 32'h0,         4'h0, 4'h0, 4'h0);
    add(5, 32'h0,         4'h0, 32'h0,         4'h0, 4'h0, 4'h0);
    add(1, 32'h0,         4'h0, 32'h0,         4'hF, 4'hF, 4'h0);
    add(1, 32'h0,         4'h0, 32'h0,         4'hF, 4'h0, 4'h0);
    add(5, 32'h0,         4'hF, 32'h0,         4'hF, 4'h0, 4'h0);
    add(1, 32'h0,         4'hF, 32'h0,         4'h0, 4'h0, 4'hF);
    add(1, 32'h0,         4'hF, 32'h0,         4'h0, 4'h0, 4'h0);

    bus.i_sw_raw    = 32'hFFFF_FFFF;
    bus.i_btn_raw_n = 4'h0;
    repeat (3) tick();
    chk("reset_state", 32'h0, 4'h0, 4'h0, 4'h0);
    bus.i_sw_raw    = '0;
    bus.i_btn_raw_n = '1;
    repeat (3) tick();
    @(negedge clk);
    rst_n = 1'b1;

    foreach (vecs[i]) begin
      bus.i_sw_raw    = vecs[i].sw;
      bus.i_btn_raw_n = vecs[i].btn_n;
      tick();
      chk($sformatf("vec%0d", i), vecs[i].e_sw, vecs[i].e_btn, vecs[i].e_pr, vecs[i].e_rel);
    end

    // Release with a 2-cycle low glitch late in the count.
    bus.i_btn_raw_n = 4'hE;
    repeat (6) tick();
    chk("glitch_press", 32'h0, 4'h1, 4'h1, 4'h0);
    tick();
    bus.i_btn_raw_n = 4'hF;
    repeat (3) tick();
    bus.i_btn_raw_n = 4'hE;
    repeat (2) tick();
    chk("glitch_hold", 32'h0, 4'h1, 4'h0, 4'h0);
    bus.i_btn_raw_n = 4'hF;
    for (int e = 1; e <= 5; e++) begin
      tick();
      chk($sformatf("glitch_restart%0d", e), 32'h0, 4'h1, 4'h0, 4'h0);
    end
    tick();
    chk("glitch_release", 32'h0, 4'h0, 4'h0, 4'h1);
    tick();
    chk("glitch_release_end", 32'h0, 4'h0, 4'h0, 4'h0);

    // Reset while button 2 is pending with count 3 and button 3 is already pressed.
    bus.i_sw_raw    = 32'hFFFF_FFFF;
    bus.i_btn_raw_n = 4'b0111;
    repeat (6) tick();
    chk("b3_press", 32'hFFFF_FFFF, 4'h8, 4'h8, 4'h0);
    bus.i_btn_raw_n = 4'b0011;
    repeat (5) tick();
    chk("b2_pending", 32'hFFFF_FFFF, 4'h8, 4'h0, 4'h0);
    #3 rst_n = 1'b0;
    #1 chk("rst_async", 32'h0, 4'h0, 4'h0, 4'h0);
    tick();
    chk("rst_held", 32'h0, 4'h0, 4'h0, 4'h0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int e = 1; e <= 7; e++) begin
      tick();
      chk($sformatf("post_rst_e%0d", e),
          (e >= 2) ? 32'hFFFF_FFFF : 32'h0,
          (e >= 6) ? 4'hC : 4'h0,
          (e == 6) ? 4'hC : 4'h0,
          4'h0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/io_input_cond.md
IO_INPUT_COND -- requirements
Module: io_input_cond

Interface
REQ-001 Parameter DEBOUNCE_CYCLES, default 50000, SHALL set the consecutive stable cycles needed to accept a button level change (1 ms at 50 MHz).
REQ-002 Parameter SYNC_STAGES, default 2, SHALL set the synchronizer depth for every raw input bit.
REQ-003 i_clk  input  1  SHALL be the single clock; all state is rising-edge.
REQ-004 i_rst_n  input  1  SHALL be the asynchronous active-low reset.
REQ-005 i_sw_raw  input  32  SHALL carry the raw asynchronous board switches.
REQ-006 i_btn_raw_n  input  4  SHALL carry the raw asynchronous push-buttons, active-low (0 = pressed).
REQ-007 o_io_sw  output  32  SHALL carry the synchronized switches and feed the CPU i_io_sw port directly.
REQ-008 o_io_btn  output  4  SHALL carry the debounced buttons, active-high (1 = pressed), and feed the CPU i_io_btn port.
REQ-009 o_btn_press  output  4  SHALL pulse high for one cycle per accepted press.
REQ-010 o_btn_release  output  4  SHALL pulse high for one cycle per accepted release.

Function
REQ-011 Each i_sw_raw bit SHALL pass through a SYNC_STAGES-deep flop chain, with o_io_sw equal to the last stage; latency SHALL be exactly SYNC_STAGES edges and switches SHALL NOT be debounced.
REQ-012 Each i_btn_raw_n bit SHALL be inverted and passed through a SYNC_STAGES-deep flop chain, giving sync_btn[i], active-high.
REQ-013 Each button SHALL run an independent FSM with states REL (stable released), PEND_DN, PRS (stable pressed) and PEND_UP, plus a counter of width $clog2(DEBOUNCE_CYCLES+1).
REQ-014 In REL with sync_btn=1, the FSM SHALL go to PEND_DN with counter=1; in PRS with sync_btn=0, it SHALL go to PEND_UP with counter=1.
REQ-015 In PEND_DN or PEND_UP, while sync_btn holds the new level, the counter SHALL increment by 1 per edge.
REQ-016 When the counter equals DEBOUNCE_CYCLES with the new level still present, the FSM SHALL enter PRS or REL on that edge and clear the counter.
REQ-017 In PEND_DN or PEND_UP, if sync_btn reverts to the old level, the FSM SHALL return to the old stable state with counter=0 and no output change.
REQ-018 With DEBOUNCE_CYCLES=1, a pending state SHALL resolve on the next edge if the level holds.
REQ-019 o_io_btn[i] SHALL be 1 exactly when the FSM is in PRS or PEND_UP.
REQ-020 End-to-end latency from a raw level held stable SHALL be SYNC_STAGES+DEBOUNCE_CYCLES edges.
REQ-021 o_btn_press[i] SHALL be high only in the first cycle o_io_btn[i] is 1; o_btn_release[i] SHALL be high only in the first cycle o_io_btn[i] returns to 0.
REQ-022 Press and release pulses SHALL never be simultaneous on one bit.
REQ-023 Buttons SHALL be fully independent, and simultaneous events on several bits SHALL each produce their own pulse in the same cycle.
REQ-024 The counter SHALL never exceed DEBOUNCE_CYCLES or wrap.

Reset
REQ-025 Reset assertion SHALL immediately force: switch sync flops to 0; button sync flops to released (sync_btn=0); all FSMs to REL; counters to 0; o_io_sw=0, o_io_btn=0, o_btn_press=0, o_btn_release=0.
REQ-026 Reset mid-debounce SHALL abandon the pending count.
REQ-027 A button held during reset release SHALL be accepted as a fresh press after SYNC_STAGES+DEBOUNCE_CYCLES edges, with one press pulse.
REQ-028 No pulse SHALL be generated by reset assertion or deassertion itself.

Structure
REQ-029 Package io_pkg SHALL hold NUM_BTN=4, NUM_SW=32 and the debounce state enum (REL, PEND_DN, PRS, PEND_UP).
REQ-030 Sub-module debounce_ch SHALL implement one button's sync chain, FSM, counter and edge pulses; io_input_cond SHALL instantiate it NUM_BTN times via generate.
REQ-031 An elaboration-time check SHALL reject DEBOUNCE_CYCLES<1 or SYNC_STAGES<2.

Verification
Benches SHALL use DEBOUNCE_CYCLES=4 and SYNC_STAGES=2.
REQ-032 i_sw_raw=32'hA5A5_0F0F, then hold -> o_io_sw=32'hA5A5_0F0F after exactly 2 edges.
REQ-033 i_btn_raw_n[0]=0, then hold -> o_io_btn[0]=1 after edge 6, o_btn_press[0]=1 for that single cycle only, other bits 0.
REQ-034 Bounce: i_btn_raw_n[1] low for 3 cycles, then high -> o_io_btn[1] stays 0, no pulses.
REQ-035 Release: button 0 pressed and stable, then raw high held -> o_io_btn[0]=0 after 6 edges, o_btn_release[0] single pulse; with 2-cycle low glitches injected mid-count, the count restarts.
REQ-036 Simultaneous: i_btn_raw_n 4'b1111 to 4'b0000 -> o_io_btn=4'hF and o_btn_press=4'hF in the same cycle.
REQ-037 Reset: i_rst_n pulsed low while button 2 is in PEND_DN with count 3 -> outputs 0 at once; button still held after release -> press accepted 6 edges later.
